// File: rtl/krot_pkg.sv
`default_nettype none
// ============================================================================
// krot_pkg : shared state type and index-width helper for kernel_rot_seq
// Rev 1.0
// ============================================================================
package krot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } krot_state_e;

  function automatic int idx_width(input int size);
    return (size * size > 1) ? $clog2(size * size) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/kernel_buf.sv
`default_nettype none
// ============================================================================
// kernel_buf : N x DW register array, one write port, asynchronous read port
// Rev 1.0
// ============================================================================
module kernel_buf #(
  parameter int N  = 25,
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] r_mem [N];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) r_mem[i] <= '0;
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/kernel_rot_seq.sv
`default_nettype none
// ============================================================================
// kernel_rot_seq : buffers a SIZE x SIZE kernel and drains it rotated 180 deg
// Optional forward pass-through selected by macro KROT_BYPASS_EN.
// Rev 1.0
// ============================================================================
module kernel_rot_seq
  import krot_pkg::*;
#(
  parameter int SIZE = 5,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last
`ifdef KROT_BYPASS_EN
  ,
  input  logic          bypass
`endif
);

  localparam int N  = SIZE * SIZE;
  localparam int AW = idx_width(SIZE);
  localparam logic [AW-1:0] c_last_idx = AW'(N - 1);

  krot_state_e   r_state;
  krot_state_e   w_state_next;
  logic [AW-1:0] r_wr_idx;
  logic [AW-1:0] r_rd_idx;
  logic          r_done;
  logic          r_err;
  logic          w_fwd;
  logic [AW-1:0] w_rd_first;
  logic [AW-1:0] w_rd_term;
  logic          w_in_beat;
  logic          w_out_beat;
  logic          w_wr_at_last;
  logic          w_rd_at_term;
  logic [DW-1:0] w_rdata;

`ifdef KROT_BYPASS_EN
  logic r_bypass;

  always_ff @(posedge clk) begin
    if (reset)                         r_bypass <= 1'b0;
    else if (r_state == IDLE && start) r_bypass <= bypass;
  end

  assign w_fwd = r_bypass;
`else
  assign w_fwd = 1'b0;
`endif

  // Reverse readout of a row-major kernel is exactly the 180 degree rotation.
  assign w_rd_first   = w_fwd ? '0 : c_last_idx;
  assign w_rd_term    = w_fwd ? c_last_idx : '0;
  assign w_in_beat    = (r_state == LOAD) && s_valid;
  assign w_out_beat   = (r_state == DRAIN) && m_ready;
  assign w_wr_at_last = (r_wr_idx == c_last_idx);
  assign w_rd_at_term = (r_rd_idx == w_rd_term);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = LOAD;
      LOAD:    if (w_in_beat && w_wr_at_last) w_state_next = DRAIN;
      DRAIN:   if (w_out_beat && w_rd_at_term) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    s_ready = (r_state == LOAD);
    m_valid = (r_state == DRAIN);
    busy    = s_ready || m_valid;
    m_data  = m_valid ? w_rdata : '0;
    m_last  = m_valid && w_rd_at_term;
  end

  // Load length is fixed by beat count; s_last only feeds the framing check.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= w_out_beat && w_rd_at_term;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_err    <= 1'b0;
            r_wr_idx <= '0;
          end
        end
        LOAD: begin
          if (w_in_beat) begin
            if (w_wr_at_last != s_last) r_err <= 1'b1;
            if (w_wr_at_last) r_rd_idx <= w_rd_first;
            else              r_wr_idx <= r_wr_idx + 1'b1;
          end
        end
        DRAIN: begin
          if (w_out_beat && !w_rd_at_term) begin
            if (w_fwd) r_rd_idx <= r_rd_idx + 1'b1;
            else       r_rd_idx <= r_rd_idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign done = r_done;
  assign err  = r_err;

  kernel_buf #(
    .N  (N),
    .DW (DW),
    .AW (AW)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .we    (w_in_beat),
    .waddr (r_wr_idx),
    .wdata (s_data),
    .raddr (r_rd_idx),
    .rdata (w_rdata)
  );

endmodule
`default_nettype wire

// File: doc/kernel_rot_seq.md
# kernel_rot_seq

Sequencer that streams a SIZE×SIZE convolution kernel in, buffers it, and streams it out rotated by 180° (element [r][c] → [SIZE-1-r][SIZE-1-c]) for the FFT/convolution datapath. One kernel is processed per `start` command, under valid/ready handshakes on both sides. It sits between the weight loader and the convolution engine and replaces array-wide parallel flipping with a serialized, backpressure-aware load/drain schedule.

## Interface
- SIZE, 5, kernel edge length; N = SIZE*SIZE elements
- DW, 32, element width
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  begin one kernel transaction; honoured only in IDLE
- busy  out  1  high in LOAD and DRAIN
- done  out  1  one-cycle pulse after the last output beat
- err  out  1  sticky framing error; cleared by an accepted start
- s_valid / s_ready  in / out  1  input handshake
- s_data  in  DW  kernel element, row-major order
- s_last  in  1  marks the final input element
- m_valid / m_ready  out / in  1  output handshake
- m_data  out  DW  rotated kernel element, row-major order
- m_last  out  1  marks the final output element
- bypass  in  1  present only with KROT_BYPASS_EN; see Configuration

## Operation
- States: IDLE → LOAD → DRAIN → IDLE.
- IDLE: s_ready=0, m_valid=0. On start=1: clear err, wr_idx=0, go to LOAD.
- LOAD: s_ready=1. Each s_valid&&s_ready beat writes buf[wr_idx] and increments wr_idx. On the N-th beat (wr_idx=N-1), go to DRAIN and set rd_idx=N-1.
- Framing: err sets if s_last=1 on any beat other than the N-th, or s_last=0 on the N-th. The load always completes on the beat count; s_last does not terminate it.
- DRAIN: m_valid=1, m_data=buf[rd_idx], m_last=(rd_idx==0). Each m_valid&&m_ready beat decrements rd_idx. The beat with rd_idx==0 goes to IDLE and pulses done in the following cycle.
- Reverse-index readout equals a 180° rotation of a row-major kernel.
- start outside IDLE is ignored; it is not queued.
- m_data, m_valid and m_last are driven only from registered state (buffer and rd_idx), with no combinational path from m_ready.
- Index counters are $clog2(N) bits wide and never wrap; terminal values are compared explicitly.

## Timing
- Reset values: s_ready=0, m_valid=0, m_last=0, m_data=0, busy=0, done=0, err=0, state=IDLE. Buffer cleared to 0.
- Reset mid-LOAD or mid-DRAIN aborts the transaction and discards the partial kernel; no done pulse.
- start at cycle t → s_ready=1 at t+1.
- Last input beat at cycle t → m_valid=1 at t+1.
- With m_ready held high, N output beats occur at t+1 … t+N, and done pulses at t+N+1.
- Minimum transaction length: 1 + N + N + 1 cycles. The next start is accepted in the cycle that done is high.
- With m_ready low, m_data and m_last hold stable.

## Configuration
- KROT_BYPASS_EN defined: the `bypass` port exists and is sampled when start is accepted. If bypass=1, DRAIN reads in forward order (rd_idx 0 → N-1, m_last at N-1), giving an unrotated pass-through.
- KROT_BYPASS_EN undefined: no `bypass` port; output is always rotated.

## Structure
- Shared package `krot_pkg`:
  - state enum {IDLE, LOAD, DRAIN}
  - function computing the index width from SIZE
- Sub-module `kernel_buf`: N×DW register array with a single write port (we, waddr, wdata) and an asynchronous read port (raddr → rdata), cleared by reset. The FSM and counters stay in `kernel_rot_seq`.

## Test plan
- SIZE=5, input 1..25 with s_last on 25, m_ready=1 → output 25,24,…,1; m_last only on 1; done 26 cycles after the last input beat; err=0.
- Same input, m_ready toggling 1,0 → identical sequence; m_data stable while m_ready=0; done after the 25th accepted beat.
- s_last asserted on element 10 → load still takes 25 beats; err=1 after beat 10; output is the full reversed sequence; err cleared by the next start.
- start pulsed during LOAD and DRAIN → ignored; exactly one done pulse; back-to-back start in the done cycle accepted.
- Reset asserted after 12 input beats → all outputs reset next cycle. A new transaction with 101..125 outputs 125…101 with no stale data.
- KROT_BYPASS_EN defined, bypass=1, input 1..25 → output 1..25 with m_last on 25. With bypass=0 → reversed.
